// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Architectural zero register: never written, never busy.
    localparam int REG_ZERO = 0;

    // One buffered MDU result at default widths (used for debug views and models).
    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between write-back, MDU, hazard unit and the arbiter.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              pipe_wr_en;
    logic [ADDR_W-1:0] pipe_wr_addr;
    logic [DATA_W-1:0] pipe_wr_data;

    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;

    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;

    logic [ADDR_W-1:0] query_a;
    logic [ADDR_W-1:0] query_b;
    logic              busy_a;
    logic              busy_b;
    logic              stall_req;

    // Core side: drives requests and queries, observes writes and hazards.
    modport master (
        output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        output mdu_valid, mdu_addr, mdu_data,
        output query_a, query_b,
        input  mdu_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
        input  busy_a, busy_b, stall_req
    );

    // Arbiter side.
    modport slave (
        input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  query_a, query_b,
        output mdu_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
        output busy_a, busy_b, stall_req
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Small circular buffer of late MDU results with per-entry kill.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    input  logic                          kill_en,
    input  logic [ADDR_W-1:0]             kill_addr,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          head_valid,
    output logic [ADDR_W-1:0]             head_addr,
    output logic [DATA_W-1:0]             head_data,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
    logic [DATA_W-1:0]            data_mem [DEPTH];

    // Pointers, occupancy and valid bits; a same-cycle push overrides a kill of its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && valid_q[i] && (addr_mem[i] == kill_addr)) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the valid bits.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_valid = valid_q[rd_ptr];
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign ent_valid  = valid_q;
    assign ent_addr   = addr_mem;

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the pipeline and buffered MDU results.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    wb_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
    localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]               count;
    logic                           head_valid;
    logic [ADDR_W-1:0]              head_addr;
    logic [DATA_W-1:0]              head_data;
    logic [BUF_DEPTH-1:0]           ent_valid;
    logic [BUF_DEPTH-1:0][ADDR_W-1:0] ent_addr;

    logic             pipe_grant;
    logic             fifo_nonempty;
    logic             pop;
    logic             accept;
    logic             push;
    logic             mdu_ready_c;
    logic             busy_a_c;
    logic             busy_b_c;

    logic [AGE_W-1:0]  age;
    logic              rf_wr_en_q;
    logic [ADDR_W-1:0] rf_wr_addr_q;
    logic [DATA_W-1:0] rf_wr_data_q;
    logic              stall_q;

    // A pipeline write to r0 is not a real write, so it leaves the slot free for draining.
    assign pipe_grant    = bus.pipe_wr_en && (bus.pipe_wr_addr != ZERO_ADDR);
    assign fifo_nonempty = (count != '0);
    assign pop           = !pipe_grant && fifo_nonempty;
    assign mdu_ready_c   = (count < CNT_W'(BUF_DEPTH));
    assign accept        = bus.mdu_valid && mdu_ready_c;
    assign push          = accept && (bus.mdu_addr != ZERO_ADDR);

    wb_result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (bus.mdu_addr),
        .push_data  (bus.mdu_data),
        .pop        (pop),
        .kill_en    (pipe_grant),
        .kill_addr  (bus.pipe_wr_addr),
        .count      (count),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .ent_valid  (ent_valid),
        .ent_addr   (ent_addr)
    );

    // A source register is busy while any live buffered or incoming MDU result targets it.
    always_comb begin
        busy_a_c = 1'b0;
        busy_b_c = 1'b0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == bus.query_a)) busy_a_c = 1'b1;
            if (ent_valid[i] && (ent_addr[i] == bus.query_b)) busy_b_c = 1'b1;
        end
        if (push && (bus.mdu_addr == bus.query_a)) busy_a_c = 1'b1;
        if (push && (bus.mdu_addr == bus.query_b)) busy_b_c = 1'b1;
        if (bus.query_a == ZERO_ADDR) busy_a_c = 1'b0;
        if (bus.query_b == ZERO_ADDR) busy_b_c = 1'b0;
    end

    // Registered write port plus head-age tracking; a killed head still occupies
    // the slot needed by the entries behind it, so it ages like a live one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            age          <= '0;
            stall_q      <= 1'b0;
        end else begin
            if (pipe_grant) begin
                rf_wr_en_q   <= 1'b1;
                rf_wr_addr_q <= bus.pipe_wr_addr;
                rf_wr_data_q <= bus.pipe_wr_data;
            end else if (pop && head_valid) begin
                rf_wr_en_q   <= 1'b1;
                rf_wr_addr_q <= head_addr;
                rf_wr_data_q <= head_data;
            end else begin
                rf_wr_en_q   <= 1'b0;
            end

            if (pop || !fifo_nonempty) begin
                age <= '0;
            end else if (age != AGE_MAX) begin
                age <= age + AGE_W'(1);
            end

            stall_q <= (age == AGE_MAX) && !pop;
        end
    end

    assign bus.mdu_ready  = mdu_ready_c;
    assign bus.busy_a     = busy_a_c;
    assign bus.busy_b     = busy_b_c;
    assign bus.rf_wr_en   = rf_wr_en_q;
    assign bus.rf_wr_addr = rf_wr_addr_q;
    assign bus.rf_wr_data = rf_wr_data_q;
    assign bus.stall_req  = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_port_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .BUF_DEPTH    (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: buffered results in arrival order, when the current head became head,
    // and the register-file write / stall expected after the last edge.
    wb_entry_t   q[$];
    int          edge_n     = 0;
    int          head_since = 0;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_stall;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_en    = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_stall = 1'b0;
    endtask

    function automatic logic busyModel(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].valid && q[i].addr == a) return 1'b1;
        if (bus.mdu_valid && q.size() < DEPTH && bus.mdu_addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model across one edge using the inputs now on the bus.
    task automatic modelStep();
        int        sz;
        int        age;
        bit        pg, pop, push, head_changed;
        wb_entry_t e;
        sz   = q.size();
        pg   = bus.pipe_wr_en && (bus.pipe_wr_addr != 5'd0);
        push = bus.mdu_valid && (sz < DEPTH) && (bus.mdu_addr != 5'd0);
        pop  = !pg && (sz > 0);
        age  = (sz > 0) ? (edge_n - head_since) : 0;
        if (age > LIMIT) age = LIMIT;
        m_stall = (sz > 0) && (age >= LIMIT) && !pop;
        if (pg) begin
            m_en   = 1'b1;
            m_addr = bus.pipe_wr_addr;
            m_data = bus.pipe_wr_data;
        end else if (pop && q[0].valid) begin
            m_en   = 1'b1;
            m_addr = q[0].addr;
            m_data = q[0].data;
        end else begin
            m_en = 1'b0;
        end
        if (pg) foreach (q[i]) if (q[i].addr == bus.pipe_wr_addr) q[i].valid = 1'b0;
        head_changed = pop || (sz == 0);
        if (pop) q.delete(0);
        if (push) begin
            e.valid = 1'b1;
            e.addr  = bus.mdu_addr;
            e.data  = bus.mdu_data;
            q.push_back(e);
        end
        if (head_changed && q.size() > 0) head_since = edge_n + 1;
    endtask

    task automatic applyStimulus(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                 input logic [4:0] qa, input logic [4:0] qb);
        @(negedge clk);
        bus.pipe_wr_en   = pe;
        bus.pipe_wr_addr = pa;
        bus.pipe_wr_data = pd;
        bus.mdu_valid    = mv;
        bus.mdu_addr     = ma;
        bus.mdu_data     = md;
        bus.query_a      = qa;
        bus.query_b      = qb;
        #1;
    endtask

    // Compare combinational outputs, clock once, then compare registered outputs.
    task automatic stepClock();
        checkOutput("mdu_ready", 32'(bus.mdu_ready), 32'(q.size() < DEPTH));
        checkOutput("busy_a", 32'(bus.busy_a), 32'(busyModel(bus.query_a)));
        checkOutput("busy_b", 32'(bus.busy_b), 32'(busyModel(bus.query_b)));
        modelStep();
        @(posedge clk);
        edge_n++;
        #1;
        checkOutput("rf_wr_en", 32'(bus.rf_wr_en), 32'(m_en));
        checkOutput("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(m_addr));
        checkOutput("rf_wr_data", bus.rf_wr_data, m_data);
        checkOutput("stall_req", 32'(bus.stall_req), 32'(m_stall));
    endtask

    task automatic idleCycle(input logic [4:0] qa);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa, 5'd0);
        stepClock();
    endtask

    initial begin
        rst = 1'b1;
        bus.pipe_wr_en = 1'b0; bus.pipe_wr_addr = '0; bus.pipe_wr_data = '0;
        bus.mdu_valid  = 1'b0; bus.mdu_addr     = '0; bus.mdu_data     = '0;
        bus.query_a    = '0;   bus.query_b      = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
        checkOutput("reset_rf_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
        checkOutput("reset_rf_wr_data", bus.rf_wr_data, 32'd0);
        checkOutput("reset_stall_req", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_mdu_ready", 32'(bus.mdu_ready), 32'd1);

        // Idle drain
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 5'd5, 5'd0);
        checkOutput("drain_busy_incoming", 32'(bus.busy_a), 32'd1);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        checkOutput("drain_busy_buffered", 32'(bus.busy_a), 32'd1);
        stepClock();
        checkOutput("drain_en", 32'(bus.rf_wr_en), 32'd1);
        checkOutput("drain_addr", 32'(bus.rf_wr_addr), 32'd5);
        checkOutput("drain_data", bus.rf_wr_data, 32'h11);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        checkOutput("drain_busy_after", 32'(bus.busy_a), 32'd0);
        stepClock();

        // Priority
        applyStimulus(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB, 5'd7, 5'd3);
        stepClock();
        checkOutput("prio_addr0", 32'(bus.rf_wr_addr), 32'd3);
        for (int i = 1; i < 3; i++) begin
            applyStimulus(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'd0, 5'd7, 5'd3);
            checkOutput("prio_ready", 32'(bus.mdu_ready), 32'd1);
            stepClock();
            checkOutput("prio_addr", 32'(bus.rf_wr_addr), 32'd3);
        end
        idleCycle(5'd0);
        checkOutput("prio_mdu_en", 32'(bus.rf_wr_en), 32'd1);
        checkOutput("prio_mdu_addr", 32'(bus.rf_wr_addr), 32'd7);
        checkOutput("prio_mdu_data", bus.rf_wr_data, 32'hBB);

        // WAW kill
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h55, 5'd4, 5'd0);
        stepClock();
        applyStimulus(1'b1, 5'd4, 32'h66, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
        stepClock();
        checkOutput("waw_pipe_data", bus.rf_wr_data, 32'h66);
        idleCycle(5'd4);
        checkOutput("waw_killed_pop_en", 32'(bus.rf_wr_en), 32'd0);
        checkOutput("waw_data_kept", bus.rf_wr_data, 32'h66);
        idleCycle(5'd4);
        checkOutput("waw_after_en", 32'(bus.rf_wr_en), 32'd0);

        // Zero register
        applyStimulus(1'b1, 5'd0, 32'h12, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0);
        checkOutput("zero_busy_a", 32'(bus.busy_a), 32'd0);
        checkOutput("zero_ready", 32'(bus.mdu_ready), 32'd1);
        stepClock();
        checkOutput("zero_en0", 32'(bus.rf_wr_en), 32'd0);
        idleCycle(5'd0);
        checkOutput("zero_en1", 32'(bus.rf_wr_en), 32'd0);

        // Full and starvation
        applyStimulus(1'b1, 5'd2, 32'h2222, 1'b1, 5'd8, 32'd1, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b1, 5'd2, 32'h2222, 1'b1, 5'd9, 32'd2, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b1, 5'd2, 32'h2222, 1'b1, 5'd10, 32'd3, 5'd10, 5'd0);
        checkOutput("full_ready", 32'(bus.mdu_ready), 32'd0);
        checkOutput("full_busy_refused", 32'(bus.busy_a), 32'd0);
        stepClock();
        for (int i = 3; i <= LIMIT; i++) begin
            applyStimulus(1'b1, 5'd2, 32'h2222, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            stepClock();
            checkOutput("starve_not_yet", 32'(bus.stall_req), 32'd0);
        end
        applyStimulus(1'b1, 5'd2, 32'h2222, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        stepClock();
        checkOutput("starve_stall", 32'(bus.stall_req), 32'd1);
        idleCycle(5'd0);
        checkOutput("starve_pop_en", 32'(bus.rf_wr_en), 32'd1);
        checkOutput("starve_pop_addr", 32'(bus.rf_wr_addr), 32'd8);
        checkOutput("starve_pop_data", bus.rf_wr_data, 32'd1);
        checkOutput("starve_stall_clear", 32'(bus.stall_req), 32'd0);
        idleCycle(5'd0);

        // Async reset with two entries buffered
        applyStimulus(1'b1, 5'd2, 32'h2222, 1'b1, 5'd13, 32'h33, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b1, 5'd2, 32'h2222, 1'b1, 5'd14, 32'h44, 5'd0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd14);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_rf_wr_en", 32'(bus.rf_wr_en), 32'd0);
        checkOutput("arst_stall", 32'(bus.stall_req), 32'd0);
        checkOutput("arst_busy_a", 32'(bus.busy_a), 32'd0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("arst_ready", 32'(bus.mdu_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idleCycle(5'd13);
            checkOutput("arst_no_stale", 32'(bus.rf_wr_en), 32'd0);
        end

        // Randomized traffic with alternating light and heavy pipeline load
        for (int n = 0; n < 3000; n++) begin
            int   load;
            logic pe, mv;
            load = ((n / 150) % 2 == 1) ? 95 : 40;
            pe   = ($urandom_range(99) < load);
            mv   = ($urandom_range(99) < 50);
            applyStimulus(pe, 5'($urandom_range(7)), $urandom,
                          mv, 5'($urandom_range(7)), $urandom,
                          5'($urandom_range(7)), 5'($urandom_range(7)));
            stepClock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
